// File: rtl/uart_rx_ctrl_if.sv
// Handshake bundle between the UART receiver framing controller and its
// environment: line/tick inputs plus the shift-register feed and status.
interface uart_rx_ctrl_if;
  logic baud_tick;
  logic rx_in;
  logic rx_bit;
  logic shift_bit;
  logic rx_done;
  logic frame_err;
  logic parity_err;
  logic busy;

  modport master (
    output baud_tick,
    output rx_in,
    input  rx_bit,
    input  shift_bit,
    input  rx_done,
    input  frame_err,
    input  parity_err,
    input  busy
  );

  modport slave (
    input  baud_tick,
    input  rx_in,
    output rx_bit,
    output shift_bit,
    output rx_done,
    output frame_err,
    output parity_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive bit-timing and framing controller: start-bit validation with
// oversampling, mid-bit data sampling into a shift register, parity/stop checks.
module uart_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);
  localparam logic          ODD_P    = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [1:0]    sync_r;
  logic          rx_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [IW-1:0] idx_r, idx_nxt_s;
  logic          acc_r, acc_nxt_s;
  logic          rx_bit_r, rx_bit_nxt_s;
  logic          shift_r, shift_nxt_s;
  logic          done_r, done_nxt_s;
  logic          ferr_r, ferr_nxt_s;
  logic          perr_r, perr_nxt_s;
  logic          busy_r;
  logic          sample_s;

  // True when received data parity plus the parity bit disagrees with the configured sense.
  function automatic logic parity_mismatch(input logic acc, input logic pbit);
    return ((acc ^ pbit) != ODD_P);
  endfunction

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx.rx_in};
    end
  end

  assign rx_s = sync_r[1];

  // Next-state and next-output logic; nothing advances without a baud tick.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    idx_nxt_s    = idx_r;
    acc_nxt_s    = acc_r;
    rx_bit_nxt_s = rx_bit_r;
    shift_nxt_s  = 1'b0;
    done_nxt_s   = 1'b0;
    ferr_nxt_s   = ferr_r;
    perr_nxt_s   = perr_r;
    sample_s     = (cnt_r == CNT_LAST);
    if (rx.baud_tick) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
      case (state_r)
        IDLE: begin
          cnt_nxt_s = CNT_ZERO;
          if (!rx_s) begin
            state_nxt_s = START;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: begin
          // Half a bit after the falling edge: low confirms a start, high was a glitch.
          if (cnt_r == CNT_HALF) begin
            cnt_nxt_s = CNT_ZERO;
            if (rx_s) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = DATA;
              ferr_nxt_s  = 1'b0;
              perr_nxt_s  = 1'b0;
              idx_nxt_s   = IDX_ZERO;
              acc_nxt_s   = 1'b0;
            end
          end else begin
            state_nxt_s = START;
          end
        end
        DATA: begin
          if (sample_s) begin
            cnt_nxt_s    = CNT_ZERO;
            rx_bit_nxt_s = rx_s;
            shift_nxt_s  = 1'b1;
            acc_nxt_s    = acc_r ^ rx_s;
            if (idx_r == IDX_LAST) begin
              idx_nxt_s   = IDX_ZERO;
              state_nxt_s = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx_nxt_s   = idx_r + IDX_ONE;
              state_nxt_s = DATA;
            end
          end else begin
            state_nxt_s = DATA;
          end
        end
        PARITY: begin
          if (sample_s) begin
            cnt_nxt_s   = CNT_ZERO;
            perr_nxt_s  = parity_mismatch(acc_r, rx_s);
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = PARITY;
          end
        end
        STOP: begin
          if (sample_s) begin
            cnt_nxt_s  = CNT_ZERO;
            done_nxt_s = 1'b1;
            if (rx_s) begin
              state_nxt_s = IDLE;
            end else begin
              ferr_nxt_s  = 1'b1;
              state_nxt_s = WAIT_HIGH;
            end
          end else begin
            state_nxt_s = STOP;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must return high before any new start is looked for.
          cnt_nxt_s = CNT_ZERO;
          if (rx_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WAIT_HIGH;
          end
        end
        default: begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      idx_r    <= IDX_ZERO;
      acc_r    <= 1'b0;
      rx_bit_r <= 1'b1;
      shift_r  <= 1'b0;
      done_r   <= 1'b0;
      ferr_r   <= 1'b0;
      perr_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      idx_r    <= idx_nxt_s;
      acc_r    <= acc_nxt_s;
      rx_bit_r <= rx_bit_nxt_s;
      shift_r  <= shift_nxt_s;
      done_r   <= done_nxt_s;
      ferr_r   <= ferr_nxt_s;
      perr_r   <= perr_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
    end
  end

  assign rx.rx_bit     = rx_bit_r;
  assign rx.shift_bit  = shift_r;
  assign rx.rx_done    = done_r;
  assign rx.frame_err  = ferr_r;
  assign rx.parity_err = perr_r;
  assign rx.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a no-parity and an even-parity instance share
// one line; a tick-position frame model is compared every cycle, plus literal checks.
module tb_uart_rx_ctrl;
  localparam int OS = 16;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b1;
  logic line = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl_if ifn ();
  uart_rx_ctrl_if ifp ();
  assign ifn.baud_tick = tick;
  assign ifn.rx_in     = line;
  assign ifp.baud_tick = tick;
  assign ifp.rx_in     = line;

  uart_rx_ctrl #(.WIDTH(W), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
    .clk(clk), .rst(rst), .rx(ifn.slave));
  uart_rx_ctrl #(.WIDTH(W), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .rx(ifp.slave));

  // Model: position in ticks since the start edge was seen; index 0 no parity, 1 even parity.
  bit m_s1[2], m_s2[2], act[2], wh[2], acc[2];
  bit e_rxb[2], e_sh[2], e_dn[2], e_fe[2], e_pe[2];
  int pos[2];

  // Bench-side shift register and event counters.
  logic [7:0] sr[2];
  int nsh[2], ndn[2], first_sh[2];
  logic [7:0] dq[$];
  int t_edge;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic mreset(input int i);
    m_s1[i] = 1'b1; m_s2[i] = 1'b1; act[i] = 1'b0; wh[i] = 1'b0; acc[i] = 1'b0;
    pos[i] = 0; e_rxb[i] = 1'b1; e_sh[i] = 1'b0; e_dn[i] = 1'b0;
    e_fe[i] = 1'b0; e_pe[i] = 1'b0;
  endtask

  task automatic mstep(input int i);
    bit ls;
    int n;
    ls = m_s2[i];
    m_s2[i] = m_s1[i];
    m_s1[i] = line;
    e_sh[i] = 1'b0;
    e_dn[i] = 1'b0;
    if (tick) begin
      if (wh[i]) begin
        if (ls) wh[i] = 1'b0;
      end else if (!act[i]) begin
        if (!ls) begin act[i] = 1'b1; pos[i] = 0; end
      end else begin
        pos[i]++;
        if (pos[i] == OS / 2) begin
          if (ls) act[i] = 1'b0;
          else begin e_fe[i] = 1'b0; e_pe[i] = 1'b0; acc[i] = 1'b0; end
        end else if (pos[i] > OS / 2 && (pos[i] - OS / 2) % OS == 0) begin
          n = (pos[i] - OS / 2) / OS;
          if (n <= W) begin
            e_rxb[i] = ls; e_sh[i] = 1'b1; acc[i] = acc[i] ^ ls;
          end else if (i == 1 && n == W + 1) begin
            e_pe[i] = (acc[i] ^ ls);
          end else begin
            e_dn[i] = 1'b1; act[i] = 1'b0;
            if (!ls) begin e_fe[i] = 1'b1; wh[i] = 1'b1; end
          end
        end
      end
    end
  endtask

  initial begin
    mreset(0);
    mreset(1);
    forever begin
      @(posedge clk or negedge rst);
      for (int i = 0; i < 2; i++) begin
        if (!rst) mreset(i);
        else mstep(i);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Compare and observe on the falling edge, away from the active edge.
  initial begin
    logic [7:0] vn, vp, en, ep;
    forever begin
      @(negedge clk);
      vn = {2'b00, ifn.rx_bit, ifn.shift_bit, ifn.rx_done, ifn.frame_err, ifn.parity_err, ifn.busy};
      vp = {2'b00, ifp.rx_bit, ifp.shift_bit, ifp.rx_done, ifp.frame_err, ifp.parity_err, ifp.busy};
      en = {2'b00, e_rxb[0], e_sh[0], e_dn[0], e_fe[0], e_pe[0], act[0] | wh[0]};
      ep = {2'b00, e_rxb[1], e_sh[1], e_dn[1], e_fe[1], e_pe[1], act[1] | wh[1]};
      chk("model_np", int'(vn), int'(en));
      chk("model_par", int'(vp), int'(ep));
      if (!rst) begin
        sr[0] = 8'h00;
        sr[1] = 8'h00;
      end else begin
        if (ifn.shift_bit) begin
          if (nsh[0] == 0) first_sh[0] = cyc;
          nsh[0]++;
          sr[0] = {ifn.rx_bit, sr[0][7:1]};
        end
        if (ifp.shift_bit) begin
          if (nsh[1] == 0) first_sh[1] = cyc;
          nsh[1]++;
          sr[1] = {ifp.rx_bit, sr[1][7:1]};
        end
        if (ifn.rx_done) begin ndn[0]++; dq.push_back(sr[0]); end
        if (ifp.rx_done) ndn[1]++;
      end
    end
  end

  task automatic clear();
    for (int i = 0; i < 2; i++) begin nsh[i] = 0; ndn[i] = 0; first_sh[i] = -1; end
    dq.delete();
  endtask

  task automatic drive_bit(input bit b, input int nclk);
    line = b;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input bit pbit);
    t_edge = cyc + 1;
    drive_bit(1'b0, OS);
    for (int k = 0; k < W; k++) drive_bit(d[k], OS);
    if (with_par) drive_bit(pbit, OS);
    drive_bit(1'b1, OS);
  endtask

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;
    sr[0] = 8'h00;
    sr[1] = 8'h00;
    clear();
    repeat (3) @(negedge clk);
    chk("reset_outputs_np", int'({ifn.rx_bit, ifn.shift_bit, ifn.rx_done, ifn.frame_err, ifn.parity_err, ifn.busy}), 'b100000);
    chk("reset_outputs_par", int'({ifp.rx_bit, ifp.shift_bit, ifp.rx_done, ifp.frame_err, ifp.parity_err, ifp.busy}), 'b100000);
    rst = 1'b1;
    drive_bit(1'b1, 5);

    // Basic 0xA5 frame, no parity.
    clear();
    send_frame(8'hA5, 1'b0, 1'b0);
    drive_bit(1'b1, 40);
    chk("a5_shifts", nsh[0], 8);
    chk("a5_data", int'(sr[0]), 'hA5);
    chk("a5_done", ndn[0], 1);
    chk("a5_frame_err", int'(ifn.frame_err), 0);
    chk("a5_first_shift_latency", first_sh[0] - t_edge, 2 + 8 + 16);

    // Four-clock glitch is rejected at the start sample point.
    clear();
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 3);
    chk("glitch_busy_in_start", int'(ifn.busy), 1);
    drive_bit(1'b1, 30);
    chk("glitch_shifts", nsh[0], 0);
    chk("glitch_done", ndn[0], 0);
    chk("glitch_busy_after", int'(ifn.busy), 0);

    // Even parity on 0x3C: correct then wrong parity bit.
    clear();
    send_frame(8'h3C, 1'b1, 1'b0);
    drive_bit(1'b1, 40);
    chk("par_ok_perr", int'(ifp.parity_err), 0);
    chk("par_ok_data", int'(sr[1]), 'h3C);
    clear();
    send_frame(8'h3C, 1'b1, 1'b1);
    drive_bit(1'b1, 40);
    chk("par_bad_perr", int'(ifp.parity_err), 1);
    chk("par_bad_shifts", nsh[1], 8);
    chk("par_bad_done", ndn[1], 1);

    // Line held low through the stop bit and beyond.
    clear();
    drive_bit(1'b0, 12 * OS);
    chk("brk_frame_err", int'(ifn.frame_err), 1);
    chk("brk_busy", int'(ifn.busy), 1);
    chk("brk_done", ndn[0], 1);
    drive_bit(1'b1, 40);
    chk("brk_idle_busy", int'(ifn.busy), 0);
    chk("brk_err_held", int'(ifn.frame_err), 1);
    clear();
    send_frame(8'h5A, 1'b0, 1'b0);
    drive_bit(1'b1, 40);
    chk("after_brk_data", int'(sr[0]), 'h5A);
    chk("after_brk_frame_err", int'(ifn.frame_err), 0);

    // Back-to-back frames without idle gap.
    clear();
    send_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    drive_bit(1'b1, 40);
    chk("b2b_shifts", nsh[0], 16);
    chk("b2b_done", ndn[0], 2);
    chk("b2b_count", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("b2b_first", int'(dq[0]), 'h01);
      chk("b2b_second", int'(dq[1]), 'hFF);
    end

    // Reset during the fourth data bit of 0xC3.
    clear();
    drive_bit(1'b0, OS);
    for (int k = 0; k < 3; k++) drive_bit(c3[k], OS);
    drive_bit(c3[3], 8);
    chk("mid_busy", int'(ifn.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_np", int'({ifn.rx_bit, ifn.shift_bit, ifn.rx_done, ifn.frame_err, ifn.parity_err, ifn.busy}), 'b100000);
    chk("mid_reset_par", int'({ifp.rx_bit, ifp.shift_bit, ifp.rx_done, ifp.frame_err, ifp.parity_err, ifp.busy}), 'b100000);
    @(negedge clk);
    line = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive_bit(1'b1, 10);
    clear();
    send_frame(8'hC3, 1'b0, 1'b0);
    drive_bit(1'b1, 40);
    chk("c3_data", int'(sr[0]), 'hC3);
    chk("c3_shifts", nsh[0], 8);
    chk("c3_done", ndn[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
